rvlab_clken_seq: RTL and testbench
==================================

Name: rvlab_clken_seq

Overview:
- Parametrised successor to the single-MMCM clock manager: gated clock enables instead of extra BUFGs, with lock-aware reset sequencing.
- Monitors the MMCM lock signal and waits for a stable-lock window.
- Releases N_CH synchronous domain resets in a staggered order, then generates one clock-enable strobe per channel with runtime divide ratio and phase.
- Sits directly behind the clock manager in the system-clock domain; drives per-subsystem resets and clock enables.

Parameters:
- N_CH, 4, number of reset/enable channels (1..16).
- DIV_W, 8, width of per-channel divide and phase fields.
- STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before reset release (>=2).
- RST_HOLD, 16, cycles between successive channel reset releases (>=1).

Ports:
- clk_i  in  1  system clock (single clock domain).
- rst_i  in  1  synchronous reset, active-high.
- locked_i  in  1  MMCM lock, asynchronous to clk_i.
- div_i  in  N_CH*DIV_W  per-channel divide ratio; channel k uses bits [k*DIV_W +: DIV_W].
- phase_i  in  N_CH*DIV_W  per-channel strobe phase, same packing as div_i.
- sync_i  in  1  single-cycle pulse; realigns all divider counters.
- rst_o  out  N_CH  per-channel synchronous reset, active-high.
- ce_o  out  N_CH  per-channel clock-enable strobe.
- ready_o  out  1  high while in RUN.
- lock_loss_cnt_o  out  8  saturating count of lock losses after first release.

Behaviour:
- Reset: one clock, clk_i; rst_i is synchronous, active-high. While rst_i=1 (sampled on a clk_i edge):
  - rst_o = all 1s; ce_o = 0; ready_o = 0; lock_loss_cnt_o = 0.
  - State = WAIT_LOCK; synchroniser flops and all counters cleared.
- Lock synchroniser: locked_i goes through a 2-flop synchroniser to give locked_s. locked_s follows locked_i with 2 cycles latency.
- WAIT_LOCK:
  - Outputs held at reset values.
  - stab_cnt is cleared whenever locked_s=0, otherwise it increments.
  - When locked_s=1 and stab_cnt = STABLE_CYCLES-1, go to RELEASE.
- Entering RELEASE, div_i and phase_i are captured into internal registers, and rel_cnt is cleared. Capture rules:
  - div=0 is stored as 1.
  - phase >= div is stored as div-1.
- RELEASE:
  - rel_cnt increments every cycle.
  - rst_o[k] deasserts on the cycle rel_cnt reaches (k+1)*RST_HOLD-1 and stays low from then on.
  - Channel 0 releases first.
  - The cycle after rst_o[N_CH-1] deasserts, go to RUN.
- RUN:
  - ready_o = 1.
  - Each channel counter cnt[k] runs 0..div[k]-1 and wraps to 0; all counters are 0 on the first RUN cycle.
  - ce_o[k] = (cnt[k] == phase[k]), a registered output: it is asserted in the same cycle as the matching count value.
  - div=1 gives ce_o[k] constant 1.
  - div_i and phase_i changes are ignored until the next RELEASE.
- sync_i:
  - In RUN, a sync_i pulse forces all cnt to 0 on the next cycle; ce_o then follows phase from 0.
  - sync_i is ignored in other states.
- Lock loss: locked_s=0 while in RELEASE or RUN causes, on the next cycle:
  - rst_o = all 1s, ce_o = 0, ready_o = 0;
  - state = WAIT_LOCK;
  - lock_loss_cnt_o increments, saturating at 255.
- Precedence on the same cycle: rst_i > lock loss > sync_i > normal counting.
- Glitches: a locked_i glitch shorter than the synchroniser sample window may be missed; that is acceptable. Any sampled drop in WAIT_LOCK restarts the stable window.
- Widths: stab_cnt and rel_cnt are clog2 sized to their terminal values. No combinational path from any input to any output.

Test Plan:
- Stable lock, N_CH=4, STABLE_CYCLES=1024, RST_HOLD=16: rst_i released, then locked_i=1 held.
  - RELEASE entered 2+1024 cycles after locked_i rises.
  - rst_o[0..3] deassert 16/32/48/64 cycles after RELEASE entry.
  - ready_o=1 one cycle after rst_o[3] deasserts.
- Divider/phase: div ch0..3 = 1, 2, 5, 0 and phase = 0, 1, 3, 9.
  - ce_o[0] is constant 1.
  - ce_o[1] pulses on odd RUN cycles.
  - ce_o[2] pulses at RUN cycles 3, 8, 13...
  - ce_o[3] is constant 1 (div 0 stored as 1, phase clamped to 0).
- Lock flicker in WAIT_LOCK: locked_i drops for 4 cycles at stab_cnt=500.
  - stab_cnt restarts.
  - RELEASE is entered a full 1024 synchronised-lock cycles after the relock.
  - lock_loss_cnt_o stays 0.
- Lock loss in RUN: locked_i drops.
  - 3 cycles later (2 synchroniser + 1): rst_o = 4'hF, ce_o = 0, ready_o = 0, lock_loss_cnt_o = 1.
  - Relock repeats the full sequence.
  - 300 losses leave lock_loss_cnt_o = 255.
- sync_i in RUN with div ch2 = 5, phase = 3, pulsed when cnt[2] = 4:
  - next cycle cnt[2] = 0;
  - ce_o[2] pulses 3 cycles after that.
- Mid-sequence reset: rst_i asserted during RELEASE with rst_o[0] already low.
  - Next cycle: all outputs at reset values.
  - lock_loss_cnt_o = 0.

Source files
------------

// File: rtl/rvlab_clken_seq.sv
// Lock-aware reset sequencer and per-channel clock-enable generator.
// Waits for a stable MMCM lock, releases channel resets in a staggered order, then emits divided enable strobes.
module rvlab_clken_seq #(
  parameter int N_CH          = 4,
  parameter int DIV_W         = 8,
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_HOLD      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    locked_i,
  input  logic [N_CH*DIV_W-1:0]   div_i,
  input  logic [N_CH*DIV_W-1:0]   phase_i,
  input  logic                    sync_i,
  output logic [N_CH-1:0]         rst_o,
  output logic [N_CH-1:0]         ce_o,
  output logic                    ready_o,
  output logic [7:0]              lock_loss_cnt_o
);

  localparam int STAB_W   = $clog2(STABLE_CYCLES);
  localparam int REL_LAST = N_CH * RST_HOLD - 1;
  localparam int REL_W    = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0]  REL_LAST_V = REL_W'(REL_LAST);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                         lock_meta;
  logic                         locked_s;
  logic [STAB_W-1:0]            stab_cnt;
  logic [REL_W-1:0]             rel_cnt;
  logic [N_CH-1:0][DIV_W-1:0]   div_q;
  logic [N_CH-1:0][DIV_W-1:0]   phase_q;
  logic [N_CH-1:0][DIV_W-1:0]   div_fix;
  logic [N_CH-1:0][DIV_W-1:0]   phase_fix;
  logic [N_CH-1:0][DIV_W-1:0]   cnt_q;
  logic [N_CH-1:0][DIV_W-1:0]   cnt_d;
  logic [N_CH-1:0]              rst_q;
  logic [N_CH-1:0]              ce_q;
  logic [N_CH-1:0]              ce_d;
  logic [7:0]                   loss_cnt;
  logic                         enter_release;
  logic                         lock_lost;

  assign enter_release = (state_q == S_WAIT_LOCK) && locked_s && (stab_cnt == STAB_LAST);
  assign lock_lost     = (state_q != S_WAIT_LOCK) && !locked_s;

  // locked_i is asynchronous to clk_i; two flops before anything looks at it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= locked_i;
      locked_s  <= lock_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (enter_release) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end else if (!rst_q[N_CH-1]) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end
      end
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  always_comb begin
    ready_o         = (state_q == S_RUN);
    rst_o           = rst_q;
    ce_o            = ce_q;
    lock_loss_cnt_o = loss_cnt;
  end

  // Any synchronised drop while waiting restarts the stable window
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != S_WAIT_LOCK) || !locked_s || enter_release) begin
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != S_RELEASE)) begin
      rel_cnt <= '0;
    end else if (rel_cnt != REL_LAST_V) begin
      rel_cnt <= rel_cnt + 1'b1;
    end
  end

  // A zero divide behaves as divide-by-one; an out-of-range phase clamps to the last count
  always_comb begin
    div_fix   = '0;
    phase_fix = '0;
    for (int k = 0; k < N_CH; k++) begin
      div_fix[k] = (div_i[k*DIV_W +: DIV_W] == '0) ? DIV_W'(1) : div_i[k*DIV_W +: DIV_W];
      phase_fix[k] = (phase_i[k*DIV_W +: DIV_W] >= div_fix[k]) ? (div_fix[k] - DIV_W'(1))
                                                               : phase_i[k*DIV_W +: DIV_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      phase_q <= '0;
    end else if (enter_release) begin
      div_q   <= div_fix;
      phase_q <= phase_fix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_d == S_WAIT_LOCK)) begin
      rst_q <= '1;
    end else if (state_q == S_RELEASE) begin
      for (int k = 0; k < N_CH; k++) begin
        if (rel_cnt == REL_W'((k + 1) * RST_HOLD - 1)) begin
          rst_q[k] <= 1'b0;
        end
      end
    end
  end

  // The strobe is computed from the next count so it lines up with the count it matches
  always_comb begin
    cnt_d = '0;
    ce_d  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if ((state_q == S_RUN) && (state_d == S_RUN) && !sync_i) begin
        cnt_d[k] = (cnt_q[k] == (div_q[k] - DIV_W'(1))) ? '0 : (cnt_q[k] + DIV_W'(1));
      end
      ce_d[k] = (state_d == S_RUN) && (cnt_d[k] == phase_q[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ce_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      loss_cnt <= '0;
    end else if (lock_lost && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rvlab_clken_seq.sv
// Self-checking bench for rvlab_clken_seq: directed timing sequences, a table of divider
// configurations and randomized traffic compared against an elapsed-time reference model.
module tb_rvlab_clken_seq;

  localparam int N_CH          = 4;
  localparam int DIV_W         = 8;
  localparam int STABLE_CYCLES = 64;
  localparam int RST_HOLD      = 16;
  localparam int EXP_LEN       = 10;
  localparam int SEQ_READY     = 2 + STABLE_CYCLES + N_CH * RST_HOLD + 1;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  locked_i;
  logic                  sync_i;
  logic [N_CH*DIV_W-1:0] div_i;
  logic [N_CH*DIV_W-1:0] phase_i;
  logic [N_CH-1:0]       rst_o;
  logic [N_CH-1:0]       ce_o;
  logic                  ready_o;
  logic [7:0]            lock_loss_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N_CH*DIV_W-1:0]        div;
    logic [N_CH*DIV_W-1:0]        phase;
    logic [N_CH-1:0][EXP_LEN-1:0] ce_exp;
  } vec_t;

  vec_t vecs [3];

  // Reference model: mode 0 waiting, 1 releasing, 2 running
  int  m_mode;
  bit  m_s1;
  bit  m_s2;
  int  m_stable;
  int  m_age;
  int  m_t;
  int  m_loss;
  int  m_div   [N_CH];
  int  m_phase [N_CH];

  int  fall_at [N_CH];
  int  ready_at;
  int  drop_left;
  bit  found;

  always #5 clk_i = ~clk_i;

  rvlab_clken_seq #(
    .N_CH          (N_CH),
    .DIV_W         (DIV_W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .RST_HOLD      (RST_HOLD)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .locked_i        (locked_i),
    .div_i           (div_i),
    .phase_i         (phase_i),
    .sync_i          (sync_i),
    .rst_o           (rst_o),
    .ce_o            (ce_o),
    .ready_o         (ready_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_lose();
    m_mode   = 0;
    m_stable = 0;
    if (m_loss < 255) m_loss++;
  endtask

  // Advances the model by one clock edge using the inputs that edge sampled
  task automatic model_advance();
    int d;
    int p;
    if (rst_i) begin
      m_mode = 0; m_s1 = 0; m_s2 = 0; m_stable = 0; m_age = 0; m_t = 0; m_loss = 0;
    end else begin
      case (m_mode)
        0: begin
          if (m_s2) begin
            m_stable++;
            if (m_stable == STABLE_CYCLES) begin
              m_mode   = 1;
              m_stable = 0;
              m_age    = 0;
              for (int k = 0; k < N_CH; k++) begin
                d = int'(div_i[k*DIV_W +: DIV_W]);
                p = int'(phase_i[k*DIV_W +: DIV_W]);
                if (d == 0) d = 1;
                if (p >= d) p = d - 1;
                m_div[k]   = d;
                m_phase[k] = p;
              end
            end
          end else begin
            m_stable = 0;
          end
        end
        1: begin
          if (!m_s2) model_lose();
          else begin
            m_age++;
            if (m_age == N_CH * RST_HOLD + 1) begin
              m_mode = 2;
              m_t    = 0;
            end
          end
        end
        default: begin
          if (!m_s2) model_lose();
          else if (sync_i) m_t = 0;
          else m_t++;
        end
      endcase
      m_s2 = m_s1;
      m_s1 = locked_i;
    end
  endtask

  function automatic logic [16:0] model_expect();
    logic [N_CH-1:0] r;
    logic [N_CH-1:0] c;
    logic            rdy;
    r   = '1;
    c   = '0;
    rdy = 1'b0;
    if (m_mode == 1) begin
      for (int k = 0; k < N_CH; k++) r[k] = (m_age < (k + 1) * RST_HOLD);
    end else if (m_mode == 2) begin
      r   = '0;
      rdy = 1'b1;
      for (int k = 0; k < N_CH; k++) c[k] = ((m_t % m_div[k]) == m_phase[k]);
    end
    return {r, c, rdy, 8'(m_loss)};
  endfunction

  // One clock: sample away from the edge, advance the model, compare everything
  task automatic step();
    @(negedge clk_i);
    model_advance();
    checkOutput("model", 32'({rst_o, ce_o, ready_o, lock_loss_cnt_o}), 32'(model_expect()));
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    locked_i  = 1'b0;
    sync_i    = 1'b0;
    drop_left = 0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic measure_sequence(input int limit);
    for (int k = 0; k < N_CH; k++) fall_at[k] = -1;
    ready_at = -1;
    for (int c = 1; c <= limit && ready_at < 0; c++) begin
      step();
      for (int k = 0; k < N_CH; k++) begin
        if (fall_at[k] < 0 && rst_o[k] == 1'b0) fall_at[k] = c;
      end
      if (ready_o) ready_at = c;
    end
  endtask

  task automatic random_cfg();
    for (int k = 0; k < N_CH; k++) begin
      div_i[k*DIV_W +: DIV_W] = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 255))
                                                            : DIV_W'($urandom_range(0, 7));
      phase_i[k*DIV_W +: DIV_W] = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 255))
                                                              : DIV_W'($urandom_range(0, 9));
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    do_reset();
    div_i    = v.div;
    phase_i  = v.phase;
    locked_i = 1'b1;
    measure_sequence(400);
    checkOutput($sformatf("vec%0d_ready", idx), 32'(ready_o), 32'd1);
    for (int c = 0; c < EXP_LEN; c++) begin
      for (int k = 0; k < N_CH; k++) begin
        checkOutput($sformatf("vec%0d_ce%0d_run%0d", idx, k, c), 32'(ce_o[k]), 32'(v.ce_exp[k][c]));
      end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0].div    = {8'd0, 8'd5, 8'd2, 8'd1};
    vecs[0].phase  = {8'd9, 8'd3, 8'd1, 8'd0};
    vecs[0].ce_exp = {10'b1111111111, 10'b0100001000, 10'b1010101010, 10'b1111111111};
    vecs[1].div    = {8'd255, 8'd7, 8'd4, 8'd3};
    vecs[1].phase  = {8'd254, 8'd6, 8'd0, 8'd2};
    vecs[1].ce_exp = {10'b0000000000, 10'b0001000000, 10'b0100010001, 10'b0100100100};
    vecs[2].div    = {8'd6, 8'd10, 8'd3, 8'd2};
    vecs[2].phase  = {8'd200, 8'd9, 8'd0, 8'd5};
    vecs[2].ce_exp = {10'b0000100000, 10'b1000000000, 10'b1001001001, 10'b1010101010};

    rst_i = 1'b1; locked_i = 1'b0; sync_i = 1'b0; div_i = '0; phase_i = '0; drop_left = 0;
    step();
    step();
    checkOutput("reset_rst", 32'(rst_o), 32'hF);
    checkOutput("reset_ce", 32'(ce_o), 32'h0);
    checkOutput("reset_ready", 32'(ready_o), 32'h0);
    checkOutput("reset_loss", 32'(lock_loss_cnt_o), 32'h0);
    rst_i = 1'b0;

    // Stable lock from cold: staggered release and ready timing
    div_i    = vecs[0].div;
    phase_i  = vecs[0].phase;
    locked_i = 1'b1;
    measure_sequence(400);
    for (int k = 0; k < N_CH; k++) begin
      checkOutput($sformatf("release_ch%0d_cycle", k), 32'(fall_at[k]),
                  32'(2 + STABLE_CYCLES + (k + 1) * RST_HOLD));
    end
    checkOutput("ready_cycle", 32'(ready_at), 32'(SEQ_READY));

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i);

    // Lock flicker partway through the stable window
    do_reset();
    div_i    = vecs[0].div;
    phase_i  = vecs[0].phase;
    locked_i = 1'b1;
    repeat (32) step();
    locked_i = 1'b0;
    repeat (4) step();
    locked_i = 1'b1;
    measure_sequence(400);
    checkOutput("flicker_release", 32'(fall_at[0]), 32'(2 + STABLE_CYCLES + RST_HOLD));
    checkOutput("flicker_ready", 32'(ready_at), 32'(SEQ_READY));
    checkOutput("flicker_loss", 32'(lock_loss_cnt_o), 32'd0);

    // Lock loss while running
    locked_i = 1'b0;
    step();
    checkOutput("loss_lat1_ready", 32'(ready_o), 32'd1);
    step();
    checkOutput("loss_lat2_ready", 32'(ready_o), 32'd1);
    step();
    checkOutput("loss_rst", 32'(rst_o), 32'hF);
    checkOutput("loss_ce", 32'(ce_o), 32'h0);
    checkOutput("loss_ready", 32'(ready_o), 32'h0);
    checkOutput("loss_cnt", 32'(lock_loss_cnt_o), 32'd1);
    locked_i = 1'b1;
    measure_sequence(400);
    checkOutput("relock_ready", 32'(ready_at), 32'(SEQ_READY));

    // sync_i on channel 2 (div 5, phase 3): once at count 4, once at count 1
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (ce_o[2]) found = 1'b1;
      else step();
    end
    checkOutput("sync_find_ce2", 32'(ce_o[2]), 32'd1);
    step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    checkOutput("sync4_ce2_c0", 32'(ce_o[2]), 32'd0);
    step();
    checkOutput("sync4_ce2_c1", 32'(ce_o[2]), 32'd0);
    step();
    checkOutput("sync4_ce2_c2", 32'(ce_o[2]), 32'd0);
    step();
    checkOutput("sync4_ce2_c3", 32'(ce_o[2]), 32'd1);
    step();
    step();
    step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    checkOutput("sync1_ce2_c0", 32'(ce_o[2]), 32'd0);
    step();
    checkOutput("sync1_ce2_c1", 32'(ce_o[2]), 32'd0);
    step();
    checkOutput("sync1_ce2_c2", 32'(ce_o[2]), 32'd0);
    step();
    checkOutput("sync1_ce2_c3", 32'(ce_o[2]), 32'd1);

    // Randomized traffic against the model
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      random_cfg();
      locked_i = 1'b1;
      for (int c = 0; c < 500; c++) begin
        step();
        sync_i = ($urandom_range(0, 9) == 0);
        if (drop_left > 0) begin
          drop_left--;
          if (drop_left == 0) locked_i = 1'b1;
        end else if ($urandom_range(0, 399) == 0) begin
          locked_i  = 1'b0;
          drop_left = int'($urandom_range(1, 6));
        end
        if ($urandom_range(0, 49) == 0) random_cfg();
        rst_i = ($urandom_range(0, 999) == 0);
      end
      sync_i = 1'b0;
      rst_i  = 1'b0;
    end

    // Saturation of the lock-loss counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      locked_i = 1'b1;
      found    = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
        step();
        if (!rst_o[0]) found = 1'b1;
      end
      checkOutput($sformatf("sat_release_%0d", i), 32'(rst_o[0]), 32'd0);
      locked_i = 1'b0;
      repeat (4) step();
      if (i == 253) checkOutput("loss_254", 32'(lock_loss_cnt_o), 32'd254);
      if (i == 254) checkOutput("loss_255", 32'(lock_loss_cnt_o), 32'd255);
    end
    checkOutput("loss_sat_300", 32'(lock_loss_cnt_o), 32'd255);

    // Reset in the middle of the release sequence
    locked_i = 1'b1;
    found    = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (!rst_o[0]) found = 1'b1;
    end
    checkOutput("mid_rst0_low", 32'(rst_o[0]), 32'd0);
    checkOutput("mid_rst1_high", 32'(rst_o[1]), 32'd1);
    rst_i = 1'b1;
    step();
    checkOutput("mid_reset_rst", 32'(rst_o), 32'hF);
    checkOutput("mid_reset_ce", 32'(ce_o), 32'h0);
    checkOutput("mid_reset_ready", 32'(ready_o), 32'h0);
    checkOutput("mid_reset_loss", 32'(lock_loss_cnt_o), 32'h0);
    rst_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
